// File: rtl/traffic_light_monitor.sv
// Passive monitor of the six lamp drive lines: decodes the lamps into phases P0..P5,
// checks the phase order and the exact dwell times, and latches the first fault cause.
module traffic_light_monitor #(
   parameter int GREEN_CYCLES  = 16,
   parameter int YELLOW_CYCLES = 4,
   parameter int ALLRED_CYCLES = 4,
   parameter int CNT_W         = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       EW_RED,
   input  logic       EW_YELLOW,
   input  logic       EW_GREEN,
   input  logic       NS_RED,
   input  logic       NS_YELLOW,
   input  logic       NS_GREEN,
   input  logic       clr_fault,
   output logic [2:0] phase,
   output logic       phase_valid,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic       cycle_done,
   output logic [7:0] cycle_count
);

   typedef enum logic {
      UNSYNC,
      LOCKED
   } state_t;

   typedef enum logic [2:0] {
      PAT_P0,
      PAT_P1,
      PAT_AR,
      PAT_P3,
      PAT_P4,
      PAT_BAD
   } pat_t;

   typedef enum logic [2:0] {
      F_NONE    = 3'd0,
      F_ILLEGAL = 3'd1,
      F_SEQ     = 3'd2,
      F_SHORT   = 3'd3,
      F_LONG    = 3'd4
   } fault_t;

   localparam logic [CNT_W-1:0] G_LIM   = CNT_W'(GREEN_CYCLES);
   localparam logic [CNT_W-1:0] Y_LIM   = CNT_W'(YELLOW_CYCLES);
   localparam logic [CNT_W-1:0] A_LIM   = CNT_W'(ALLRED_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state, state_n;
   logic [2:0]       cur_phase, phase_n;
   logic [CNT_W-1:0] dwell_cnt, dwell_n;
   logic             partial, partial_n;
   logic             fault_q, fault_n;
   fault_t           code_q, code_n;
   logic             done_q, done_n;
   logic [7:0]       count_q, count_n;

   pat_t             pat;
   logic [2:0]       nxt_phase;
   logic [CNT_W-1:0] lim;
   logic             raise;
   fault_t           raise_code;
   logic             wrap;
   logic             fault_base;
   fault_t           code_base;

   // All-red has a single pattern code; which of P2/P5 it means follows from the current phase.
   function automatic pat_t pat_of(input logic [2:0] p);
      case (p)
         3'd0:    return PAT_P0;
         3'd1:    return PAT_P1;
         3'd3:    return PAT_P3;
         3'd4:    return PAT_P4;
         default: return PAT_AR;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] lim_of(input logic [2:0] p);
      case (p)
         3'd0, 3'd3: return G_LIM;
         3'd1, 3'd4: return Y_LIM;
         default:    return A_LIM;
      endcase
   endfunction

   always_comb begin
      case ({NS_GREEN, NS_YELLOW, NS_RED, EW_GREEN, EW_YELLOW, EW_RED})
         6'b100_001: pat = PAT_P0;
         6'b010_001: pat = PAT_P1;
         6'b001_001: pat = PAT_AR;
         6'b001_100: pat = PAT_P3;
         6'b001_010: pat = PAT_P4;
         default:    pat = PAT_BAD;
      endcase
   end

   assign nxt_phase = (cur_phase == 3'd5) ? 3'd0 : cur_phase + 3'd1;
   assign lim       = lim_of(cur_phase);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= UNSYNC;
         cur_phase <= '0;
         dwell_cnt <= '0;
         partial   <= 1'b0;
         fault_q   <= 1'b0;
         code_q    <= F_NONE;
         done_q    <= 1'b0;
         count_q   <= '0;
      end else begin
         state     <= state_n;
         cur_phase <= phase_n;
         dwell_cnt <= dwell_n;
         partial   <= partial_n;
         fault_q   <= fault_n;
         code_q    <= code_n;
         done_q    <= done_n;
         count_q   <= count_n;
      end
   end

   always_comb begin
      state_n    = state;
      phase_n    = cur_phase;
      dwell_n    = dwell_cnt;
      partial_n  = partial;
      raise      = 1'b0;
      raise_code = F_NONE;
      wrap       = 1'b0;
      case (state)
         UNSYNC: begin
            if (pat == PAT_P0) begin
               state_n   = LOCKED;
               phase_n   = 3'd0;
               dwell_n   = CNT_ONE;
               partial_n = 1'b1;
            end
         end
         LOCKED: begin
            if (pat == PAT_BAD) begin
               raise      = 1'b1;
               raise_code = F_ILLEGAL;
               state_n    = UNSYNC;
               dwell_n    = '0;
            end else if (pat == pat_of(cur_phase)) begin
               // Saturating at lim+1 makes the long-dwell report fire exactly once per phase.
               if (dwell_cnt <= lim) dwell_n = dwell_cnt + CNT_ONE;
               if (dwell_cnt == lim) begin
                  raise      = 1'b1;
                  raise_code = F_LONG;
               end
            end else if (pat == pat_of(nxt_phase)) begin
               if (dwell_cnt < lim && !partial) begin
                  raise      = 1'b1;
                  raise_code = F_SHORT;
               end
               wrap      = (cur_phase == 3'd5);
               phase_n   = nxt_phase;
               dwell_n   = CNT_ONE;
               partial_n = 1'b0;
            end else begin
               raise      = 1'b1;
               raise_code = F_SEQ;
               state_n    = UNSYNC;
               dwell_n    = '0;
            end
         end
         default: state_n = UNSYNC;
      endcase

      // A clear and a new fault in the same cycle: the clear applies first, so the new cause is kept.
      fault_base = clr_fault ? 1'b0 : fault_q;
      code_base  = clr_fault ? F_NONE : code_q;
      fault_n    = fault_base | raise;
      code_n     = (raise && !fault_base) ? raise_code : code_base;
      done_n     = wrap;
      count_n    = count_q + {7'd0, wrap};
   end

   always_comb begin
      phase       = (state == LOCKED) ? cur_phase : 3'd7;
      phase_valid = (state == LOCKED);
      fault       = fault_q;
      fault_code  = code_q;
      cycle_done  = done_q;
      cycle_count = count_q;
   end

endmodule
